alu_rr_arbiter: RTL and testbench
=================================

Name: alu_rr_arbiter

Overview:
- Shares one 4-bit ALU between NUM_REQ requesters using round-robin arbitration.
- Accepts one operation at a time over a per-requester valid/ready handshake and drives the ALU operand/op inputs.
- Captures the ALU result one cycle after issue and returns it on a shared response bus, qualified by a one-hot rsp_valid.
- Sits between the requesters and the ALU; it is the only driver of the ALU inputs.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- IDX_W, $clog2(NUM_REQ), width of grant index (derived, not overridable).

Ports:
- clk  input  1  clock, all logic on posedge.
- resetn  input  1  synchronous active-low reset.
- req_valid  input  NUM_REQ  per-requester request valid.
- req_ready  output  NUM_REQ  per-requester accept; one-hot or zero.
- req_operandA  input  NUM_REQ*4  packed operand A, requester i at [4i+3:4i].
- req_operandB  input  NUM_REQ*4  packed operand B.
- req_op  input  NUM_REQ*2  packed op code (0 OR, 1 AND, 2 XOR, 3 all-ones).
- rsp_valid  output  NUM_REQ  one-hot response valid to the owning requester.
- rsp_ready  input  NUM_REQ  per-requester response accept.
- rsp_result  output  4  shared response data.
- alu_operandA  output  4  to ALU operandA.
- alu_operandB  output  4  to ALU operandB.
- alu_op  output  2  to ALU op.
- alu_done  input  1  from ALU done; sticky-high after the first operation.
- alu_result  input  4  from ALU result.
- proto_err  output  1  sticky: alu_done was low in CAPTURE.

Behaviour:
- Reset (resetn=0 at posedge) forces all of the following to 0:
  - state (to IDLE), rsp_valid, rsp_result, alu_operandA, alu_operandB, alu_op, proto_err.
  - req_ready is 0 while resetn=0.
  - last_grant is set to NUM_REQ-1, so requester 0 wins first.
- FSM states: IDLE, ISSUE, CAPTURE, RESP.
- IDLE:
  - If any req_valid is set, the winner is the first set bit searching from last_grant+1 upward, wrapping at NUM_REQ-1 to 0.
  - req_ready[winner]=1 combinationally in this cycle.
  - At the edge: register the winner's operands into alu_operandA/B/alu_op and the winner into grant; go to ISSUE.
  - If no req_valid is set: req_ready=0 and remain in IDLE.
- ISSUE: ALU inputs held stable; the ALU samples them at the end of this cycle. Go to CAPTURE.
- CAPTURE:
  - rsp_result <= alu_result.
  - If alu_done==0, set proto_err=1 (cleared only by reset).
  - Go to RESP.
- RESP:
  - rsp_valid[grant]=1, rsp_result held stable.
  - On rsp_ready[grant]=1: clear rsp_valid, set last_grant<=grant, go to IDLE.
  - rsp_ready on other bits is ignored.
- Timing:
  - Latency: accept at cycle N gives rsp_valid at N+3.
  - Minimum issue interval is 4 cycles; the next grant can occur in the cycle after the response handshake.
- req_ready is never asserted outside IDLE.
- ALU input registers hold their value between operations; no change unless granted.
- Requester rules: a requester may drop req_valid before acceptance without effect. The arbiter does not require valid to be held; it samples only in the accept cycle.
- Simultaneous req_valid from all requesters: strict rotation 0,1,2,3,0,…
- Reset mid-operation: the in-flight op is discarded with no response, and the FSM returns to IDLE.

Optional Feature:
- ALU_ARB_PERF_EN defined: adds output busy_cnt [15:0] and output grant_cnt [NUM_REQ*16-1:0].
  - busy_cnt increments every cycle state!=IDLE, saturating at 0xFFFF.
  - grant_cnt[i] increments on each accept for requester i, saturating.
  - All counters reset to 0.
- Undefined: these ports and counters do not exist, and the rest of the behaviour is identical.

Decomposition:
- Package alu_arb_pkg holds:
  - typedef enum logic [1:0] alu_op_e {OP_OR=0, OP_AND=1, OP_XOR=2, OP_ONES=3}.
  - typedef enum logic [1:0] arb_state_e {IDLE, ISSUE, CAPTURE, RESP}.
  - localparam OPERAND_W=4.
- Sub-module rr_pick (combinational: req vector, last_grant gives found flag and winner index) is natural and reusable.

Test Plan:
- Reset then a single request: req0 valid, A=4'hA, B=4'h5, op=0. Expect req_ready[0] in cycle 0, rsp_valid[0] at cycle 3 with result 4'hF, proto_err=0.
- All four valid continuously with rsp_ready tied high. Expect grant order 0,1,2,3,0 and an accept every 4 cycles. Use op=2 with A=4'hC, B=4'hA, giving result 4'h6 each time.
- Back-pressure: req1 op=1, A=4'hC, B=4'hA, rsp_ready[1]=0 for 5 cycles. Expect rsp_valid[1] and result 4'h8 held stable, and req_ready stays 0 for all requesters.
- Wrong-requester ready: in RESP for requester 2, pulse rsp_ready[0] only. Expect no state change; FSM exits only on rsp_ready[2].
- Reset asserted in CAPTURE. Expect rsp_valid=0 next cycle, IDLE, alu_* =0, and requester 0 wins the next arbitration.
- op=3 from req3 with any operands gives result 4'hF. Force alu_done=0 during CAPTURE and expect proto_err=1 sticky until reset.

Source files
------------

// File: rtl/alu_arb_pkg.sv
// Shared types and constants for the round-robin ALU arbiter.
package alu_arb_pkg;

  localparam int OPERAND_W = 4;

  typedef enum logic [1:0] {
    OP_OR   = 2'd0,
    OP_AND  = 2'd1,
    OP_XOR  = 2'd2,
    OP_ONES = 2'd3
  } alu_op_e;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    CAPTURE,
    RESP
  } arb_state_e;

endpackage

// File: rtl/alu_rr_arbiter_rr_pick.sv
// Combinational round-robin picker: first set request strictly after
// last_grant, wrapping from NUM_REQ-1 back to 0.
module rr_pick
  import alu_arb_pkg::*;
#(
  parameter  int NUM_REQ = 4,
  localparam int IDX_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   last_grant,
  output logic               found,
  output logic [IDX_W-1:0]   winner
);

  logic [IDX_W-1:0] cand;

  // Walk from the farthest candidate down to the nearest so the nearest
  // requester after last_grant is the one left standing.
  always_comb begin
    // NOTE: every output gets a default first so no path can infer a latch.
    found  = 1'b0;
    winner = '0;
    cand   = '0;
    for (int i = NUM_REQ; i >= 1; i--) begin
      cand = IDX_W'((int'(last_grant) + i) % NUM_REQ);
      if (req[cand]) begin
        found  = 1'b1;
        winner = cand;
      end
    end
  end

endmodule

// File: rtl/alu_rr_arbiter.sv
// Round-robin arbiter sharing one 4-bit ALU between NUM_REQ requesters.
// Define ALU_ARB_PERF_EN to add the busy_cnt / grant_cnt performance counters.
module alu_rr_arbiter
  import alu_arb_pkg::*;
#(
  parameter int NUM_REQ = 4
) (
  input  logic                     clk,
  input  logic                     resetn,
  input  logic [NUM_REQ-1:0]       req_valid,
  output logic [NUM_REQ-1:0]       req_ready,
  input  logic [NUM_REQ*4-1:0]     req_operandA,
  input  logic [NUM_REQ*4-1:0]     req_operandB,
  input  logic [NUM_REQ*2-1:0]     req_op,
  output logic [NUM_REQ-1:0]       rsp_valid,
  input  logic [NUM_REQ-1:0]       rsp_ready,
  output logic [3:0]               rsp_result,
  output logic [3:0]               alu_operandA,
  output logic [3:0]               alu_operandB,
  output logic [1:0]               alu_op,
  input  logic                     alu_done,
  input  logic [3:0]               alu_result,
  output logic                     proto_err
`ifdef ALU_ARB_PERF_EN
  ,
  output logic [15:0]              busy_cnt,
  output logic [NUM_REQ*16-1:0]    grant_cnt
`endif
);

  localparam int IDX_W = $clog2(NUM_REQ);

  arb_state_e           state_q, state_d;
  logic [IDX_W-1:0]     grant_q, grant_d;
  logic [IDX_W-1:0]     last_grant_q, last_grant_d;
  logic [OPERAND_W-1:0] alu_a_q, alu_a_d;
  logic [OPERAND_W-1:0] alu_b_q, alu_b_d;
  alu_op_e              alu_op_q, alu_op_d;
  logic [OPERAND_W-1:0] rsp_result_q, rsp_result_d;
  logic [NUM_REQ-1:0]   rsp_valid_q, rsp_valid_d;
  logic                 proto_err_q, proto_err_d;

  logic                 pick_found;
  logic [IDX_W-1:0]     pick_idx;
  logic                 accept;

  rr_pick #(.NUM_REQ(NUM_REQ)) u_pick (
    .req        (req_valid),
    .last_grant (last_grant_q),
    .found      (pick_found),
    .winner     (pick_idx)
  );

  // Acceptance is purely combinational in IDLE and suppressed while in reset.
  assign accept = resetn && (state_q == IDLE) && pick_found;

  always_comb begin
    req_ready = '0;
    if (accept) req_ready[pick_idx] = 1'b1;
  end

  always_comb begin
    state_d      = state_q;
    grant_d      = grant_q;
    last_grant_d = last_grant_q;
    alu_a_d      = alu_a_q;
    alu_b_d      = alu_b_q;
    alu_op_d     = alu_op_q;
    rsp_result_d = rsp_result_q;
    rsp_valid_d  = rsp_valid_q;
    proto_err_d  = proto_err_q;
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          grant_d  = pick_idx;
          alu_a_d  = req_operandA[int'(pick_idx)*OPERAND_W +: OPERAND_W];
          alu_b_d  = req_operandB[int'(pick_idx)*OPERAND_W +: OPERAND_W];
          alu_op_d = alu_op_e'(req_op[int'(pick_idx)*2 +: 2]);
          state_d  = ISSUE;
        end
      end
      ISSUE: state_d = CAPTURE;
      CAPTURE: begin
        rsp_result_d          = alu_result;
        if (!alu_done) proto_err_d = 1'b1;
        rsp_valid_d           = '0;
        rsp_valid_d[grant_q]  = 1'b1;
        state_d               = RESP;
      end
      RESP: begin
        // Only the owning requester's ready can complete the response.
        if (rsp_ready[grant_q]) begin
          rsp_valid_d  = '0;
          last_grant_d = grant_q;
          state_d      = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments keep every flop updating from pre-edge values.
    if (!resetn) begin
      state_q      <= IDLE;
      grant_q      <= '0;
      last_grant_q <= IDX_W'(NUM_REQ - 1);
      alu_a_q      <= '0;
      alu_b_q      <= '0;
      alu_op_q     <= OP_OR;
      rsp_result_q <= '0;
      rsp_valid_q  <= '0;
      proto_err_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      last_grant_q <= last_grant_d;
      alu_a_q      <= alu_a_d;
      alu_b_q      <= alu_b_d;
      alu_op_q     <= alu_op_d;
      rsp_result_q <= rsp_result_d;
      rsp_valid_q  <= rsp_valid_d;
      proto_err_q  <= proto_err_d;
    end
  end

  assign alu_operandA = alu_a_q;
  assign alu_operandB = alu_b_q;
  assign alu_op       = alu_op_q;
  assign rsp_result   = rsp_result_q;
  assign rsp_valid    = rsp_valid_q;
  assign proto_err    = proto_err_q;

`ifdef ALU_ARB_PERF_EN
  logic [15:0]           busy_cnt_q, busy_cnt_d;
  logic [NUM_REQ*16-1:0] grant_cnt_q, grant_cnt_d;

  always_comb begin
    busy_cnt_d  = busy_cnt_q;
    grant_cnt_d = grant_cnt_q;
    if (state_q != IDLE && busy_cnt_q != 16'hFFFF) busy_cnt_d = busy_cnt_q + 16'd1;
    if (accept && grant_cnt_q[int'(pick_idx)*16 +: 16] != 16'hFFFF)
      grant_cnt_d[int'(pick_idx)*16 +: 16] = grant_cnt_q[int'(pick_idx)*16 +: 16] + 16'd1;
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      busy_cnt_q  <= '0;
      grant_cnt_q <= '0;
    end else begin
      busy_cnt_q  <= busy_cnt_d;
      grant_cnt_q <= grant_cnt_d;
    end
  end

  assign busy_cnt  = busy_cnt_q;
  assign grant_cnt = grant_cnt_q;
`endif

endmodule

// File: tb/tb_alu_rr_arbiter.sv
// Self-checking bench for alu_rr_arbiter: transaction-level model plus directed vectors.
module tb_alu_rr_arbiter;

  localparam int N = 4;

  logic           clk = 1'b0;
  logic           resetn;
  logic [N-1:0]   req_valid, req_ready, rsp_valid, rsp_ready;
  logic [N*4-1:0] req_operandA, req_operandB;
  logic [N*2-1:0] req_op;
  logic [3:0]     rsp_result, alu_operandA, alu_operandB, alu_result;
  logic [1:0]     alu_op;
  logic           alu_done, proto_err;

  int tests = 0;
  int fails = 0;
  int cyc_cnt = 0;
  bit cmp_en = 1'b0;
  bit log_en = 1'b0;
  int log_idx[$];
  int log_cyc[$];

  always #5 clk = ~clk;

  alu_rr_arbiter #(.NUM_REQ(N)) dut (
    .clk          (clk),
    .resetn       (resetn),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_operandA (req_operandA),
    .req_operandB (req_operandB),
    .req_op       (req_op),
    .rsp_valid    (rsp_valid),
    .rsp_ready    (rsp_ready),
    .rsp_result   (rsp_result),
    .alu_operandA (alu_operandA),
    .alu_operandB (alu_operandB),
    .alu_op       (alu_op),
    .alu_done     (alu_done),
    .alu_result   (alu_result),
    .proto_err    (proto_err)
  );

  function automatic logic [3:0] alu_fn(input logic [1:0] op, input logic [3:0] a, input logic [3:0] b);
    case (op)
      2'd0:    return a | b;
      2'd1:    return a & b;
      2'd2:    return a ^ b;
      default: return 4'hF;
    endcase
  endfunction

  // Registered ALU: samples its inputs every edge, so the ISSUE-cycle
  // operands are visible on alu_result during CAPTURE.
  always @(posedge clk) alu_result <= alu_fn(alu_op, alu_operandA, alu_operandB);

  always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

  // Transaction model: one op in flight, aged by cycles since acceptance.
  bit         m_busy;
  int         m_age, m_owner, m_last, m_win;
  logic [3:0] m_a, m_b, m_res;
  logic [1:0] m_op;
  logic       m_perr;

  function automatic int rr_winner(input int last, input logic [N-1:0] v);
    for (int k = 1; k <= N; k++) begin
      int j = (last + k) % N;
      if (v[j]) return j;
    end
    return -1;
  endfunction

  always_comb m_win = rr_winner(m_last, req_valid);

  always @(posedge clk) begin
    if (!resetn) begin
      m_busy <= 1'b0; m_age <= 0; m_owner <= 0; m_last <= N - 1;
      m_a <= '0; m_b <= '0; m_op <= '0; m_res <= '0; m_perr <= 1'b0;
    end else if (!m_busy) begin
      if (m_win >= 0) begin
        m_busy  <= 1'b1;
        m_age   <= 1;
        m_owner <= m_win;
        m_a     <= req_operandA[m_win*4 +: 4];
        m_b     <= req_operandB[m_win*4 +: 4];
        m_op    <= req_op[m_win*2 +: 2];
      end
    end else begin
      if (m_age == 2) begin
        m_res <= alu_fn(m_op, m_a, m_b);
        if (!alu_done) m_perr <= 1'b1;
      end
      if (m_age >= 3 && rsp_ready[m_owner]) begin
        m_busy <= 1'b0;
        m_last <= m_owner;
      end else if (m_age < 3) begin
        m_age <= m_age + 1;
      end
    end
  end

  function automatic logic [N-1:0] exp_ready_f();
    logic [N-1:0] r = '0;
    if (resetn && !m_busy && m_win >= 0) r[m_win] = 1'b1;
    return r;
  endfunction

  function automatic logic [N-1:0] exp_valid_f();
    logic [N-1:0] r = '0;
    if (m_busy && m_age >= 3) r[m_owner] = 1'b1;
    return r;
  endfunction

  function automatic int onehot_idx(input logic [N-1:0] v);
    for (int i = 0; i < N; i++) if (v[i]) return i;
    return -1;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc_cnt);
    end
  endtask

  always @(negedge clk) begin
    if (cmp_en) begin
      check("cmp_req_ready",  req_ready,    exp_ready_f());
      check("cmp_rsp_valid",  rsp_valid,    exp_valid_f());
      check("cmp_rsp_result", rsp_result,   m_res);
      check("cmp_alu_a",      alu_operandA, m_a);
      check("cmp_alu_b",      alu_operandB, m_b);
      check("cmp_alu_op",     alu_op,       m_op);
      check("cmp_proto_err",  proto_err,    m_perr);
      if (log_en && req_ready != '0) begin
        log_idx.push_back(onehot_idx(req_ready));
        log_cyc.push_back(cyc_cnt);
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic reset_dut();
    resetn    = 1'b0;
    req_valid = '1;
    rsp_ready = '0;
    alu_done  = 1'b1;
    cyc();
    cmp_en = 1'b1;
    cyc();
    resetn    = 1'b1;
    req_valid = '0;
  endtask

  task automatic set_req(input int i, input logic [3:0] a, input logic [3:0] b, input logic [1:0] op);
    req_valid[i]          = 1'b1;
    req_operandA[i*4 +: 4] = a;
    req_operandB[i*4 +: 4] = b;
    req_op[i*2 +: 2]      = op;
  endtask

  // Lone request with rsp_ready high: accept in cycle 0, response in cycle 3.
  task automatic run_single(input int i, input logic [3:0] a, input logic [3:0] b,
                            input logic [1:0] op, input logic [3:0] exp_res, input string tag);
    logic [N-1:0] oh;
    oh = '0;
    oh[i] = 1'b1;
    rsp_ready = '1;
    set_req(i, a, b, op);
    @(negedge clk); check({tag, "_ready"}, req_ready, oh);
    cyc();
    req_valid = '0;
    @(negedge clk);
    @(negedge clk); check({tag, "_no_early_rsp"}, rsp_valid, '0);
    @(negedge clk); check({tag, "_rsp_valid"}, rsp_valid, oh);
    check({tag, "_result"}, rsp_result, exp_res);
    cyc();
    @(negedge clk); check({tag, "_rsp_clear"}, rsp_valid, '0);
    cyc();
  endtask

  initial begin
    int exp_order[5] = '{0, 1, 2, 3, 0};
    req_operandA = '0; req_operandB = '0; req_op = '0;
    req_valid = '0; rsp_ready = '0; alu_done = 1'b1; resetn = 1'b0;

    // Reset state
    reset_dut();
    @(negedge clk);
    check("rst_alu_a", alu_operandA, 4'h0);
    check("rst_rsp_valid", rsp_valid, '0);
    check("rst_proto_err", proto_err, 1'b0);
    check("rst_req_ready", req_ready, '0);
    cyc();

    // Single OR request from requester 0
    run_single(0, 4'hA, 4'h5, 2'd0, 4'hF, "t1");
    check("t1_proto_err", proto_err, 1'b0);

    // All four valid, rsp_ready high: strict rotation, one accept every 4 cycles
    reset_dut();
    rsp_ready = '1;
    for (int i = 0; i < N; i++) set_req(i, 4'hC, 4'hA, 2'd2);
    log_idx.delete(); log_cyc.delete();
    log_en = 1'b1;
    for (int k = 0; k < 17; k++) begin
      @(negedge clk);
      if (k == 3) check("t2_result", rsp_result, 4'h6);
      cyc();
    end
    log_en = 1'b0;
    req_valid = '0;
    repeat (5) cyc();
    check("t2_accepts", log_idx.size(), 5);
    for (int i = 0; i < 5 && i < log_idx.size(); i++) begin
      check("t2_order", log_idx[i], exp_order[i]);
      if (i > 0) check("t2_interval", log_cyc[i] - log_cyc[i-1], 4);
    end

    // Back-pressure on requester 1 while 0 and 2 keep requesting
    rsp_ready = '0;
    set_req(1, 4'hC, 4'hA, 2'd1);
    @(negedge clk); check("t3_ready", req_ready, 4'b0010);
    cyc();
    req_valid = 4'b0101;
    for (int k = 1; k <= 7; k++) begin
      @(negedge clk);
      check("t3_no_ready", req_ready, '0);
      if (k >= 3) begin
        check("t3_hold_valid", rsp_valid, 4'b0010);
        check("t3_hold_result", rsp_result, 4'h8);
      end
      cyc();
    end
    req_valid = '0;
    rsp_ready = 4'b0010;
    @(negedge clk); check("t3_last_valid", rsp_valid, 4'b0010);
    cyc();
    @(negedge clk); check("t3_released", rsp_valid, '0);
    cyc();
    rsp_ready = '0;

    // Wrong-requester ready is ignored in RESP
    set_req(2, 4'h3, 4'h6, 2'd2);
    @(negedge clk); check("t4_ready", req_ready, 4'b0100);
    cyc();
    req_valid = '0;
    @(negedge clk);
    @(negedge clk);
    cyc();
    rsp_ready = 4'b0001;
    @(negedge clk); check("t4_valid", rsp_valid, 4'b0100);
    check("t4_result", rsp_result, 4'h5);
    cyc();
    @(negedge clk); check("t4_wrong_ready", rsp_valid, 4'b0100);
    rsp_ready = 4'b0100;
    cyc();
    @(negedge clk); check("t4_done", rsp_valid, '0);
    cyc();
    rsp_ready = '0;

    // Reset asserted during CAPTURE discards the op
    set_req(3, 4'h5, 4'h3, 2'd0);
    @(negedge clk); check("t5_ready", req_ready, 4'b1000);
    cyc();
    req_valid = '0;
    cyc();
    resetn = 1'b0;
    @(negedge clk); check("t5_ready_in_rst", req_ready, '0);
    cyc();
    resetn = 1'b1;
    for (int i = 0; i < N; i++) set_req(i, 4'h9, 4'h1, 2'd0);
    @(negedge clk);
    check("t5_rsp_valid", rsp_valid, '0);
    check("t5_alu_a", alu_operandA, 4'h0);
    check("t5_alu_b", alu_operandB, 4'h0);
    check("t5_alu_op", alu_op, 2'd0);
    check("t5_req0_wins", req_ready, 4'b0001);
    rsp_ready = '1;
    cyc();
    req_valid = '0;
    repeat (4) cyc();

    // All-ones op with alu_done low during CAPTURE -> sticky proto_err
    set_req(3, 4'h2, 4'h4, 2'd3);
    @(negedge clk); check("t6_ready", req_ready, 4'b1000);
    cyc();
    req_valid = '0;
    cyc();
    alu_done = 1'b0;
    cyc();
    alu_done = 1'b1;
    @(negedge clk);
    check("t6_valid", rsp_valid, 4'b1000);
    check("t6_result", rsp_result, 4'hF);
    check("t6_proto_err", proto_err, 1'b1);
    cyc();
    run_single(1, 4'h1, 4'h2, 2'd0, 4'h3, "t6b");
    check("t6_sticky", proto_err, 1'b1);
    reset_dut();
    @(negedge clk); check("t6_cleared", proto_err, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

endmodule
